// File: rtl/ecc_pkg.sv
// Shared ECC datapath definitions: FSM state encoding, mode selectors and default field width.
package ecc_pkg;

  localparam int ECC_N = 231;

  localparam logic MODE_INV = 1'b0;
  localparam logic MODE_DIV = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/mod_half_step.sv
// Combinational modular halving: returns y/2 mod p for odd p, with y in [0,p-1].
module mod_half_step
  import ecc_pkg::*;
#(
  parameter int N = ECC_N
) (
  input  logic [N-1:0] y,
  input  logic [N-1:0] p,
  output logic [N-1:0] h
);

  logic [N:0] sum;
  logic [N:0] sel;

  // An odd y is made even by adding p; the extra carry bit keeps the sum exact.
  always_comb begin
    sum = {1'b0, y} + {1'b0, p};
    sel = y[0] ? sum : {1'b0, y};
    h   = N'(sel >> 1);
  end

endmodule

// File: rtl/mod_inv_div.sv
// Modular inverse / division over GF(p) by binary extended Euclid, one reduction step per clock.
module mod_inv_div
  import ecc_pkg::*;
#(
  parameter int N        = ECC_N,
  parameter int MAX_ITER = 4*N + 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         mode,
  input  logic [N-1:0] p,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         ready,
  output logic         done,
  output logic [N-1:0] x,
  output logic         err
);

  localparam int IW = $clog2(MAX_ITER + 1);

  state_t        state;
  logic [N-1:0]  p_r;
  logic [N-1:0]  a_r;
  logic [N-1:0]  b_r;
  logic          mode_r;
  logic [N-1:0]  u;
  logic [N-1:0]  v;
  logic [N-1:0]  x1;
  logic [N-1:0]  x2;
  logic [IW-1:0] iter;

  logic [N-1:0]  x1_half;
  logic [N-1:0]  x2_half;
  logic [N:0]    x1_minus_x2;
  logic [N:0]    x2_minus_x1;
  logic [N-1:0]  x1_sub;
  logic [N-1:0]  x2_sub;
  logic          bad_input;
  logic          iter_last;

  mod_half_step #(.N(N)) u_half_x1 (
    .y (x1),
    .p (p_r),
    .h (x1_half)
  );

  mod_half_step #(.N(N)) u_half_x2 (
    .y (x2),
    .p (p_r),
    .h (x2_half)
  );

  // A borrow out of the N+1-bit difference means the result went negative; adding p
  // modulo 2^N then lands it back in [0,p-1].
  always_comb begin
    x1_minus_x2 = {1'b0, x1} - {1'b0, x2};
    x2_minus_x1 = {1'b0, x2} - {1'b0, x1};
    x1_sub = x1_minus_x2[N] ? (x1_minus_x2[N-1:0] + p_r) : x1_minus_x2[N-1:0];
    x2_sub = x2_minus_x1[N] ? (x2_minus_x1[N-1:0] + p_r) : x2_minus_x1[N-1:0];
    bad_input = !p_r[0] || (p_r < N'(3)) || (a_r == '0) || (a_r >= p_r) ||
                ((mode_r == MODE_DIV) && (b_r >= p_r));
    iter_last = (iter == IW'(MAX_ITER - 1));
  end

  // Control FSM and datapath registers; done is a one-cycle pulse raised on entry to DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      ready  <= 1'b1;
      done   <= 1'b0;
      x      <= '0;
      err    <= 1'b0;
      iter   <= '0;
      p_r    <= '0;
      a_r    <= '0;
      b_r    <= '0;
      mode_r <= MODE_INV;
      u      <= '0;
      v      <= '0;
      x1     <= '0;
      x2     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            p_r    <= p;
            a_r    <= a;
            b_r    <= b;
            mode_r <= mode;
            ready  <= 1'b0;
            state  <= CHECK;
          end
        end

        CHECK: begin
          if (bad_input) begin
            err   <= 1'b1;
            x     <= '0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            u     <= a_r;
            v     <= p_r;
            x1    <= (mode_r == MODE_DIV) ? b_r : N'(1);
            x2    <= '0;
            iter  <= '0;
            state <= RUN;
          end
        end

        RUN: begin
          iter <= iter + IW'(1);
          if (u == N'(1)) begin
            x     <= x1;
            err   <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else if (v == N'(1)) begin
            x     <= x2;
            err   <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else if ((u == '0) || (v == '0) || iter_last) begin
            // Common factor with p, or the watchdog ran out.
            x     <= '0;
            err   <= 1'b1;
            done  <= 1'b1;
            state <= DONE;
          end else if (!u[0]) begin
            u  <= u >> 1;
            x1 <= x1_half;
          end else if (!v[0]) begin
            v  <= v >> 1;
            x2 <= x2_half;
          end else if (u >= v) begin
            u  <= u - v;
            x1 <= x1_sub;
          end else begin
            v  <= v - u;
            x2 <= x2_sub;
          end
        end

        DONE: begin
          ready <= 1'b1;
          state <= IDLE;
        end

        default: begin
          ready <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mod_inv_div.sv
// Self-checking bench for mod_inv_div: directed cases plus random operands against a Euclid-based model.
module tb_mod_inv_div;
  import ecc_pkg::*;

  localparam int TN = 256;
  localparam logic [TN-1:0] P256 =
    256'hFFFFFFFF00000001000000000000000000000000FFFFFFFFFFFFFFFFFFFFFFFF;

  typedef logic [2*TN+1:0] wide_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          mode;
  logic [TN-1:0] p;
  logic [TN-1:0] a;
  logic [TN-1:0] b;
  logic          ready;
  logic          done;
  logic [TN-1:0] x;
  logic          err;

  int checks   = 0;
  int failures = 0;

  mod_inv_div #(.N(TN)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .mode  (mode),
    .p     (p),
    .a     (a),
    .b     (b),
    .ready (ready),
    .done  (done),
    .x     (x),
    .err   (err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [TN-1:0] obs, input logic [TN-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Textbook extended Euclid with division; coefficients kept reduced mod p.
  function automatic void refModel(input logic m, input logic [TN-1:0] pn, input logic [TN-1:0] an,
                                   input logic [TN-1:0] bn, output logic [TN-1:0] ex, output logic ee);
    wide_t pp, r0, r1, rt, q, t0, t1, tt;
    pp = wide_t'(pn);
    if (!pn[0] || pn < 3 || an == 0 || an >= pn || (m && bn >= pn)) begin
      ex = '0;
      ee = 1'b1;
      return;
    end
    r0 = pp;
    r1 = wide_t'(an);
    t0 = '0;
    t1 = wide_t'(1);
    while (r1 != 0) begin
      q  = r0 / r1;
      rt = r0 - q * r1;
      r0 = r1;
      r1 = rt;
      tt = (q * t1) % pp;
      tt = t0 + pp - tt;
      if (tt >= pp) tt = tt - pp;
      t0 = t1;
      t1 = tt;
    end
    if (r0 != 1) begin
      ex = '0;
      ee = 1'b1;
    end else begin
      ee = 1'b0;
      ex = m ? TN'((wide_t'(bn) * t0) % pp) : TN'(t0);
    end
  endfunction

  task automatic applyStimulus(input logic m, input logic [TN-1:0] pp, input logic [TN-1:0] aa,
                               input logic [TN-1:0] bb, output logic [TN-1:0] rx, output logic re,
                               output int lat);
    int guard = 0;
    while (!ready && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    mode  = m;
    p     = pp;
    a     = aa;
    b     = bb;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    while (!done && lat < 5000) begin
      @(negedge clk);
      lat++;
    end
    if (!done) checkOutput("done_timeout", TN'(done), TN'(1));
    rx = x;
    re = err;
  endtask

  task automatic runCase(input string tag, input logic m, input logic [TN-1:0] pp,
                         input logic [TN-1:0] aa, input logic [TN-1:0] bb, output int lat);
    logic [TN-1:0] rx, ex;
    logic re, ee;
    applyStimulus(m, pp, aa, bb, rx, re, lat);
    refModel(m, pp, aa, bb, ex, ee);
    checkOutput({tag, "_x"}, rx, ex);
    checkOutput({tag, "_err"}, TN'(re), TN'(ee));
  endtask

  function automatic logic [TN-1:0] rand256();
    logic [TN-1:0] r;
    for (int i = 0; i < TN / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  initial begin
    logic [TN-1:0] rx, ra, rb, rp;
    logic re, rm;
    int lat, guard, done_seen;

    reset = 1'b1;
    start = 1'b0;
    mode  = MODE_INV;
    p = '0;
    a = '0;
    b = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checkOutput("rst_ready", TN'(ready), TN'(1));
    checkOutput("rst_done", TN'(done), TN'(0));
    checkOutput("rst_x", x, TN'(0));
    checkOutput("rst_err", TN'(err), TN'(0));

    applyStimulus(MODE_INV, TN'(23), TN'(5), TN'(0), rx, re, lat);
    checkOutput("inv5_x", rx, TN'(14));
    checkOutput("inv5_err", TN'(re), TN'(0));
    applyStimulus(MODE_DIV, TN'(23), TN'(5), TN'(7), rx, re, lat);
    checkOutput("div7_5_x", rx, TN'(6));
    checkOutput("div7_5_err", TN'(re), TN'(0));
    applyStimulus(MODE_INV, TN'(23), TN'(1), TN'(0), rx, re, lat);
    checkOutput("inv1_x", rx, TN'(1));
    checkOutput("inv1_lat", TN'(lat), TN'(3));

    applyStimulus(MODE_INV, TN'(23), TN'(0), TN'(0), rx, re, lat);
    checkOutput("a0_err", TN'(re), TN'(1));
    checkOutput("a0_x", rx, TN'(0));
    checkOutput("a0_lat", TN'(lat), TN'(2));
    applyStimulus(MODE_INV, TN'(23), TN'(23), TN'(0), rx, re, lat);
    checkOutput("aeqp_err", TN'(re), TN'(1));
    checkOutput("aeqp_lat", TN'(lat), TN'(2));
    applyStimulus(MODE_INV, TN'(22), TN'(5), TN'(0), rx, re, lat);
    checkOutput("peven_err", TN'(re), TN'(1));
    checkOutput("peven_lat", TN'(lat), TN'(2));
    applyStimulus(MODE_DIV, TN'(23), TN'(5), TN'(30), rx, re, lat);
    checkOutput("bbig_err", TN'(re), TN'(1));
    checkOutput("bbig_x", rx, TN'(0));
    checkOutput("bbig_lat", TN'(lat), TN'(2));
    applyStimulus(MODE_INV, TN'(23), TN'(5), TN'(30), rx, re, lat);
    checkOutput("bignored_x", rx, TN'(14));

    applyStimulus(MODE_INV, TN'(21), TN'(6), TN'(0), rx, re, lat);
    checkOutput("gcd3_err", TN'(re), TN'(1));
    checkOutput("gcd3_x", rx, TN'(0));
    checkOutput("gcd3_before_wd", TN'(lat < 4*TN + 6), TN'(1));
    applyStimulus(MODE_INV, TN'(21), TN'(4), TN'(0), rx, re, lat);
    checkOutput("inv4_21_x", rx, TN'(16));
    checkOutput("inv4_21_err", TN'(re), TN'(0));

    // A start arriving in the DONE cycle must not be accepted.
    applyStimulus(MODE_INV, TN'(23), TN'(5), TN'(0), rx, re, lat);
    a = TN'(7);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("start_in_done_ignored", TN'(ready), TN'(1));
    checkOutput("x_held", x, TN'(14));

    // A start pulsed while busy must not disturb the running operation.
    mode = MODE_INV;
    p = TN'(23);
    a = TN'(5);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = TN'(7);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (!done && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("busy_done_seen", TN'(done), TN'(1));
    checkOutput("busy_start_ignored_x", x, TN'(14));

    // Reset ten cycles into a long run aborts it with no done pulse.
    @(negedge clk);
    mode = MODE_INV;
    p = P256;
    a = rand256() % P256;
    if (a == 0) a = TN'(3);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("abort_ready", TN'(ready), TN'(1));
    checkOutput("abort_done", TN'(done), TN'(0));
    checkOutput("abort_x", x, TN'(0));
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    checkOutput("abort_no_done", TN'(done_seen), TN'(0));

    for (int i = 0; i < 30; i++) begin
      ra = rand256() % P256;
      if (ra == 0) ra = TN'(1);
      rb = rand256() % P256;
      rm = 1'(i % 2);
      runCase("p256", rm, P256, ra, rb, lat);
      checkOutput("p256_latency", TN'(lat <= 4*TN + 3), TN'(1));
    end

    for (int i = 0; i < 60; i++) begin
      rp = TN'($urandom_range(3, 255) | 1);
      if ($urandom_range(0, 7) == 0) rp = rp - TN'(1);
      ra = TN'($urandom_range(0, 32'(rp)));
      rb = TN'($urandom_range(0, 32'(rp) + 3));
      rm = 1'($urandom_range(0, 1));
      runCase("small", rm, rp, ra, rb, lat);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
